morse_letter_sequencer: RTL and testbench

MORSE_LETTER_SEQUENCER -- requirements
Module: morse_letter_sequencer

---
 rtl/morse_letter_sequencer.sv | 116 +++++++++++
 tb/tb_morse_letter_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/morse_letter_sequencer.sv
// Show-ahead character FIFO fed by a Morse decoder, with an optional word-gap space inserter.
// Define MORSE_SEQ_SPACE_EN to build the key-idle gap FSM; otherwise only letter_valid pushes.
module morse_letter_sequencer #(
   parameter int unsigned DEPTH    = 8,
   parameter logic [31:0] WORD_GAP = 32'd350_000_000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     key,
   input  logic [7:0]               letter_in,
   input  logic                     letter_valid,
   input  logic                     clear_ovf,
   output logic [7:0]               out_char,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("morse_letter_sequencer: DEPTH must be a power of two in 2..64");
   end

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level_q;
   logic          ovf_q;
   logic          push, pop, full, push_ok, drop;
   logic [7:0]    push_data;

`ifdef MORSE_SEQ_SPACE_EN
   typedef enum logic {S_IDLE, S_ARMED} gap_state_t;
   gap_state_t  state_q, state_d;
   logic [31:0] gap_q, gap_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
      end
   end

   // A letter always outranks a space due in the same cycle.
   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      push      = 1'b0;
      push_data = letter_in;
      case (state_q)
         S_IDLE: begin
            if (letter_valid) begin
               push    = 1'b1;
               gap_d   = '0;
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (letter_valid) begin
               push  = 1'b1;
               gap_d = '0;
            end else if (key) begin
               gap_d = '0;
            end else if (gap_q == WORD_GAP - 32'd1) begin
               push      = 1'b1;
               push_data = 8'h20;
               gap_d     = '0;
               state_d   = S_IDLE;
            end else if (gap_q != '1) begin
               gap_d = gap_q + 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
`else
   logic unused_cfg;
   assign unused_cfg = key ^ (WORD_GAP != 32'd0);
   assign push       = letter_valid;
   assign push_data  = letter_in;
`endif

   assign full    = (level_q == LW'(DEPTH));
   assign pop     = out_valid && out_ready;
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         level_q <= level_q + LW'(push_ok) - LW'(pop);
         if (drop)           ovf_q <= 1'b1;
         else if (clear_ovf) ovf_q <= 1'b0;
      end
   end

   // Storage is deliberately left out of reset; level gates what is visible.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   assign out_valid = (level_q != '0);
   assign out_char  = out_valid ? mem[rd_ptr] : 8'h00;
   assign level     = level_q;
   assign overflow  = ovf_q;
endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Scoreboard bench for morse_letter_sequencer (DEPTH=4, WORD_GAP=10); gap checks follow MORSE_SEQ_SPACE_EN.
module tb_morse_letter_sequencer;
   logic       clk = 1'b0, reset = 1'b1, key = 1'b0, letter_valid = 1'b0;
   logic       clear_ovf = 1'b0, out_ready = 1'b0;
   logic [7:0] letter_in = 8'h00;
   logic [7:0] out_char;
   logic       out_valid, overflow;
   logic [2:0] level;

   int n_chk = 0, n_fail = 0;
   logic [7:0] sb[$];

   morse_letter_sequencer #(.DEPTH(4), .WORD_GAP(32'd10)) dut (
      .clk(clk), .reset(reset), .key(key), .letter_in(letter_in),
      .letter_valid(letter_valid), .clear_ovf(clear_ovf), .out_char(out_char),
      .out_valid(out_valid), .out_ready(out_ready), .level(level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one letter strobe; record it on the scoreboard only if the model says it fits.
   task automatic push_letter(input logic [7:0] c);
      letter_in    = c;
      letter_valid = 1'b1;
      if (sb.size() < 4) sb.push_back(c);
      cyc();
      letter_valid = 1'b0;
   endtask

   task automatic pop_chk(input string tag);
      logic [7:0] exp;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      exp = sb.pop_front();
      chk({tag, "_vld"}, out_valid, 1);
      chk(tag, out_char, exp);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
   endtask

   initial begin
      cyc(2);
      chk("rst_vld", out_valid, 0);
      chk("rst_lvl", level, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_char", out_char, 8'h00);
      reset = 1'b0;
      key   = 1'b1;
      cyc();

      // first push shows up the following cycle
      push_letter(8'h53);
      chk("first_vld", out_valid, 1);
      chk("first_char", out_char, 8'h53);
      chk("first_lvl", level, 1);
      pop_chk("first_pop");
      chk("first_empty", level, 0);

`ifdef MORSE_SEQ_SPACE_EN
      key = 1'b0;
      push_letter(8'h41);
      cyc(9);
      chk("gap_pre", level, 1);
      cyc();
      sb.push_back(8'h20);
      chk("gap_space", level, 2);
      cyc(20);
      chk("gap_idle", level, 2);
      pop_chk("gap_pop_a");
      pop_chk("gap_pop_sp");

      // letter lands on the very cycle the space would fire
      push_letter(8'h42);
      cyc(9);
      push_letter(8'h43);
      chk("race_lvl", level, 2);
      cyc(9);
      chk("race_rearm", level, 2);
      cyc();
      sb.push_back(8'h20);
      chk("race_space", level, 3);
      pop_chk("race_pop0");
      pop_chk("race_pop1");
      pop_chk("race_pop2");
`else
      key = 1'b0;
      push_letter(8'h41);
      cyc(50);
      chk("nogap_lvl", level, 1);
      pop_chk("nogap_pop");
`endif
      key = 1'b1;

      // overflow: fifth push dropped, contents kept
      for (int i = 0; i < 5; i++) push_letter(8'h61 + 8'(i));
      chk("ovf_lvl", level, 4);
      chk("ovf_set", overflow, 1);
      clear_ovf = 1'b1;
      push_letter(8'h66);
      clear_ovf = 1'b0;
      chk("ovf_drop_wins", overflow, 1);
      clear_ovf = 1'b1;
      cyc();
      clear_ovf = 1'b0;
      chk("ovf_clr", overflow, 0);

      // push while full and popping in the same cycle
      chk("full_head", out_char, sb.pop_front());
      letter_in    = 8'h45;
      letter_valid = 1'b1;
      out_ready    = 1'b1;
      cyc();
      letter_valid = 1'b0;
      out_ready    = 1'b0;
      sb.push_back(8'h45);
      chk("full_pp_lvl", level, 4);
      chk("full_pp_ovf", overflow, 0);
      for (int i = 0; i < 4; i++) pop_chk($sformatf("full_pop%0d", i));
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("pop_empty_lvl", level, 0);
      chk("pop_empty_vld", out_valid, 0);

      // asynchronous reset in the middle of a clock phase
      push_letter(8'h71);
      push_letter(8'h72);
      push_letter(8'h73);
      chk("pre_rst_lvl", level, 3);
      #2 reset = 1'b1;
      #1;
      chk("async_vld", out_valid, 0);
      chk("async_lvl", level, 0);
      chk("async_char", out_char, 8'h00);
      sb.delete();
      cyc();
      reset = 1'b0;
      cyc();
      push_letter(8'h7a);
      chk("post_rst_lvl", level, 1);
      pop_chk("post_rst_pop");

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
